// File: rtl/cordic_dir_encoder_if.sv
// Job handshake and cell-0 output bundle for the CORDIC direction encoder.
// The slave modport is the encoder side, and the master modport is the requester/consumer side.
interface cordic_dir_encoder_if #(
    parameter int ITER = 11,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] angle;
    logic [DW-1:0]        x_in;
    logic [DW-1:0]        y_in;
    logic                 out_valid;
    logic [ITER-1:0]      index_cor;
    logic [DW-1:0]        XM;
    logic [DW-1:0]        YM;
    logic [DW-1:0]        XR;
    logic [DW-1:0]        YR;
    logic [AW-1:0]        z_res;
    logic                 out_clamped;

    modport slave (
        input  in_valid, angle, x_in, y_in,
        output in_ready, out_valid, index_cor, XM, YM, XR, YR, z_res, out_clamped
    );

    modport master (
        output in_valid, angle, x_in, y_in,
        input  in_ready, out_valid, index_cor, XM, YM, XR, YR, z_res, out_clamped
    );
endinterface

// File: rtl/cordic_dir_encoder.sv
// Front end of the CORDIC rotation pipeline. It resolves one rotation-direction bit per cycle
// from the target angle, then presents the bits with the initial vector to cell 0.
module cordic_dir_encoder #(
    parameter int ITER = 11,
    parameter int AW   = 16,
    parameter int DW   = 16
) (
    input logic                 clk,
    input logic                 reset,
    cordic_dir_encoder_if.slave bus
);
    localparam int CW = $clog2(ITER);
    localparam logic signed [AW-1:0] ANG_MAX = AW'(12868);
    localparam logic signed [AW-1:0] ANG_MIN = -ANG_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] z_q;
    logic [ITER-1:0]      bits_q;
    logic [DW-1:0]        xWork_q, yWork_q;
    logic                 clampWork_q;
    logic                 outValid_q;
    logic [ITER-1:0]      indexCor_q;
    logic [DW-1:0]        xOut_q, yOut_q;
    logic [AW-1:0]        zRes_q;
    logic                 clamped_q;

    logic signed [AW-1:0] angleSat_d;
    logic                 clampHit_d;
    logic signed [AW-1:0] atan_d;
    logic signed [AW-1:0] zNext_d;
    logic [ITER-1:0]      bitsNext_d;

    // arctan(2^-i) in Q3.13 radians
    always_comb begin
        atan_d = '0;
        case (cnt_q)
            4'd0:    atan_d = AW'(6434);
            4'd1:    atan_d = AW'(3798);
            4'd2:    atan_d = AW'(2007);
            4'd3:    atan_d = AW'(1019);
            4'd4:    atan_d = AW'(511);
            4'd5:    atan_d = AW'(256);
            4'd6:    atan_d = AW'(128);
            4'd7:    atan_d = AW'(64);
            4'd8:    atan_d = AW'(32);
            4'd9:    atan_d = AW'(16);
            4'd10:   atan_d = AW'(8);
            default: atan_d = '0;
        endcase
    end

    // Saturating to +/-pi/2 keeps every later add/subtract inside 16 bits
    always_comb begin
        angleSat_d = bus.angle;
        clampHit_d = 1'b0;
        if (bus.angle > ANG_MAX) begin
            angleSat_d = ANG_MAX;
            clampHit_d = 1'b1;
        end else if (bus.angle < ANG_MIN) begin
            angleSat_d = ANG_MIN;
            clampHit_d = 1'b1;
        end
        bitsNext_d         = bits_q;
        bitsNext_d[cnt_q]  = ~z_q[AW-1];
        zNext_d            = z_q[AW-1] ? (z_q + atan_d) : (z_q - atan_d);
    end

    // Output registers load only on the final iteration, so the chain never sees partial work
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            z_q         <= '0;
            bits_q      <= '0;
            xWork_q     <= '0;
            yWork_q     <= '0;
            clampWork_q <= 1'b0;
            outValid_q  <= 1'b0;
            indexCor_q  <= '0;
            xOut_q      <= '0;
            yOut_q      <= '0;
            zRes_q      <= '0;
            clamped_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        xWork_q     <= bus.x_in;
                        yWork_q     <= bus.y_in;
                        z_q         <= angleSat_d;
                        clampWork_q <= clampHit_d;
                        bits_q      <= '0;
                        cnt_q       <= '0;
                        state_q     <= S_ITER;
                    end
                end
                S_ITER: begin
                    z_q    <= zNext_d;
                    bits_q <= bitsNext_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q    <= S_DONE;
                        outValid_q <= 1'b1;
                        indexCor_q <= bitsNext_d;
                        zRes_q     <= zNext_d;
                        xOut_q     <= xWork_q;
                        yOut_q     <= yWork_q;
                        clamped_q  <= clampWork_q;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = outValid_q;
    assign bus.index_cor   = indexCor_q;
    assign bus.XM          = xOut_q;
    assign bus.YM          = yOut_q;
    assign bus.XR          = xOut_q;
    assign bus.YR          = yOut_q;
    assign bus.z_res       = zRes_q;
    assign bus.out_clamped = clamped_q;
endmodule

// File: tb/tb_cordic_dir_encoder.sv
// Bench for cordic_dir_encoder. Each result is compared against an integer model of the
// direction-bit recurrence, with directed cases for the zero angle, pi/4, clamping, busy and abort.
module tb_cordic_dir_encoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cordic_dir_encoder_if bus ();

    cordic_dir_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected cell-0 bundle {index_cor, z_res, XM, YM, XR, YR, out_clamped} from plain integer math
    function automatic logic [91:0] expPack(input int ang, input logic [15:0] x, input logic [15:0] y);
        int          atanTab[11] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8};
        int          z;
        logic [10:0] bits;
        logic        cl;
        z  = ang;
        cl = 1'b0;
        if (z > 12868) begin z = 12868; cl = 1'b1; end
        else if (z < -12868) begin z = -12868; cl = 1'b1; end
        for (int i = 0; i < 11; i++) begin
            if (z >= 0) begin bits[i] = 1'b1; z = z - atanTab[i]; end
            else begin bits[i] = 1'b0; z = z + atanTab[i]; end
        end
        return {bits, 16'(z), x, y, x, y, cl};
    endfunction

    function automatic logic [91:0] actPack();
        return {bus.index_cor, bus.z_res, bus.XM, bus.YM, bus.XR, bus.YR, bus.out_clamped};
    endfunction

    // Submits one job when idle and returns the negedge count to its strobe (-1 on timeout)
    task automatic applyStimulus(input int ang, input logic [15:0] x, input logic [15:0] y, output int lat);
        for (int k = 0; k < 30 && !bus.in_ready; k++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.angle    = 16'(ang);
        bus.x_in     = x;
        bus.y_in     = y;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 25) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hs: ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (actPack() !== 92'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want 0", actPack());
        end
    endtask

    task automatic test_zero_angle();
        int lat;
        applyStimulus(0, 16'h1000, 16'h0000, lat);
        checks++;
        if (lat !== 12) begin errors++; $display("[TB] FAIL zero_latency: got %0d want 12", lat); end
        checks++;
        if (bus.index_cor !== 11'h0D1) begin errors++; $display("[TB] FAIL zero_index: got %h want 0d1", bus.index_cor); end
        checks++;
        if (bus.z_res !== 16'hFFFF) begin errors++; $display("[TB] FAIL zero_zres: got %h want ffff", bus.z_res); end
        checks++;
        if ({bus.XM, bus.XR, bus.YM, bus.YR, bus.out_clamped} !== {16'h1000, 16'h1000, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zero_vector: got XM=%h XR=%h YM=%h YR=%h cl=%b want 1000 1000 0 0 0",
                     bus.XM, bus.XR, bus.YM, bus.YR, bus.out_clamped);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.index_cor !== 11'h0D1) begin
            errors++;
            $display("[TB] FAIL zero_strobe_len: valid=%b index=%h want 0 and 0d1", bus.out_valid, bus.index_cor);
        end
    endtask

    task automatic test_pi4();
        int lat;
        applyStimulus(6434, 16'h0800, 16'h0400, lat);
        checks++;
        if (lat !== 12 || bus.index_cor !== 11'h783 || bus.z_res !== 16'd3 || bus.out_clamped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pi4: lat=%0d index=%h zres=%h cl=%b want 12 783 0003 0",
                     lat, bus.index_cor, bus.z_res, bus.out_clamped);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || actPack() !== 92'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: ready=%b valid=%b outs=%h want 1 0 0", bus.in_ready, bus.out_valid, actPack());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_clamp();
        int angs[4] = '{20000, 12868, -20000, -12868};
        int lat;
        logic [91:0] want;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(angs[i], 16'(16'h1234 + i), 16'(16'h0F00 - i), lat);
            want = expPack(angs[i], 16'(16'h1234 + i), 16'(16'h0F00 - i));
            checks++;
            if (lat !== 12 || actPack() !== want) begin
                errors++;
                $display("[TB] FAIL clamp_%0d: lat=%0d got %h want %h", angs[i], lat, actPack(), want);
            end
        end
        checks++;
        if (expPack(20000, 0, 0) >> 1 !== expPack(12868, 0, 0) >> 1 || bus.out_clamped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_equiv: clamped=%b want 0 after unclamped job", bus.out_clamped);
        end
    endtask

    task automatic test_random();
        int ang, lat;
        logic [15:0] x, y;
        logic [91:0] want;
        for (int n = 0; n < 10; n++) begin
            ang = int'($urandom_range(40000)) - 20000;
            x   = 16'($urandom);
            y   = 16'($urandom);
            applyStimulus(ang, x, y, lat);
            want = expPack(ang, x, y);
            checks++;
            if (lat !== 12 || actPack() !== want) begin
                errors++;
                $display("[TB] FAIL random_%0d: ang=%0d lat=%0d got %h want %h", n, ang, lat, actPack(), want);
            end
        end
    endtask

    task automatic test_busy();
        logic [91:0] q[$];
        logic [91:0] held, want;
        logic        have = 1'b0;
        int          lastStrobe = -1;
        int          ang;
        logic [15:0] x, y;
        for (int k = 0; k < 30 && !bus.in_ready; k++) @(negedge clk);
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (bus.out_valid) begin
                want = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if (actPack() !== want) begin
                    errors++;
                    $display("[TB] FAIL busy_data_c%0d: got %h want %h", cyc, actPack(), want);
                end
                if (lastStrobe >= 0) begin
                    checks++;
                    if (cyc - lastStrobe !== 13) begin
                        errors++;
                        $display("[TB] FAIL busy_interval: got %0d want 13", cyc - lastStrobe);
                    end
                end
                lastStrobe = cyc;
                held = want;
                have = 1'b1;
            end else if (have) begin
                checks++;
                if (actPack() !== held) begin
                    errors++;
                    $display("[TB] FAIL busy_stable_c%0d: got %h want %h", cyc, actPack(), held);
                end
            end
            ang = int'($urandom_range(30000)) - 15000;
            x   = 16'($urandom);
            y   = 16'($urandom);
            bus.in_valid = 1'b1;
            bus.angle    = 16'(ang);
            bus.x_in     = x;
            bus.y_in     = y;
            if (bus.in_ready) q.push_back(expPack(ang, x, y));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            if (bus.out_valid) begin
                want = q.pop_front();
                checks++;
                if (actPack() !== want) begin
                    errors++;
                    $display("[TB] FAIL busy_drain: got %h want %h", actPack(), want);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() !== 0 || lastStrobe < 0) begin
            errors++;
            $display("[TB] FAIL busy_missing: pending=%0d lastStrobe=%0d want 0 and >=0", q.size(), lastStrobe);
        end
    endtask

    task automatic test_abort();
        int lat;
        logic stale = 1'b0;
        for (int k = 0; k < 30 && !bus.in_ready; k++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.angle    = 16'(int'($urandom_range(20000)) - 10000);
        bus.x_in     = 16'h5555;
        bus.y_in     = 16'h2222;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_reset: ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (bus.out_valid) stale = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stale !== 1'b0) begin errors++; $display("[TB] FAIL abort_stale: got strobe=%b want 0", stale); end
        applyStimulus(0, 16'h1000, 16'h0000, lat);
        checks++;
        if (lat !== 12 || bus.index_cor !== 11'h0D1 || bus.z_res !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL abort_rerun: lat=%0d index=%h zres=%h want 12 0d1 ffff", lat, bus.index_cor, bus.z_res);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.angle    = '0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_zero_angle();
        test_pi4();
        test_async_reset();
        test_clamp();
        test_random();
        test_busy();
        test_abort();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_dir_encoder.md
Name: cordic_dir_encoder

Overview:
Front-end stage of the CORDIC rotation pipeline. It accepts a target angle and an input vector, then iteratively computes the 11 rotation-direction bits that the downstream CORDIC cell chain reads from index_cor. It presents those bits together with the registered initial vector (XM, YM, XR, YR) to cell 0 of the chain. Upstream uses a valid/ready handshake; the downstream side gets a one-cycle out_valid strobe with held data.

Parameters:
ITER, 11, number of direction bits / iterations; equals the index_cor width.
AW, 16, angle and residual width, signed Q3.13 radians.
DW, 16, vector component width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream request: angle, x_in and y_in are valid.
in_ready  output  1  block can accept a job.
angle  input  16  signed Q3.13 target angle in radians.
x_in  input  16  initial vector X.
y_in  input  16  initial vector Y.
out_valid  output  1  one-cycle strobe: outputs hold a completed job.
index_cor  output  11  direction bits; bit i is used by cell i.
XM  output  16  initial X for cell 0.
YM  output  16  initial Y for cell 0.
XR  output  16  initial shift operand X for cell 0 (equals XM).
YR  output  16  initial shift operand Y for cell 0 (equals YM).
z_res  output  16  final angle residual, for verification.
out_clamped  output  1  angle was saturated at capture.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; in_ready=1; out_valid=0.
  - index_cor, XM, YM, XR, YR, z_res and out_clamped all = 0; iteration counter i=0.
  - Reset asserted mid-job aborts the job. No out_valid is produced for it.
- FSM states: IDLE, ITER, DONE.
  - in_ready = (state==IDLE), combinational from the state register.
- IDLE:
  - On an edge with in_valid=1: capture x_in and y_in into XM/XR and YM/YR; capture angle into z; clear the index_cor working register; i=0; go to ITER.
  - Angle saturation at capture: angle>12868 becomes 12868; angle<-12868 becomes -12868 (±pi/2). out_clamped is set when saturation occurs, otherwise cleared.
- ITER, one iteration per cycle:
  - If z>=0 (sign bit 0): bit[i]=1 and z=z-ATAN[i].
  - Otherwise: bit[i]=0 and z=z+ATAN[i].
  - Arithmetic is 16-bit two's complement. With clamped input no overflow is possible.
  - i increments each cycle. The cycle that processes i=ITER-1 transitions to DONE.
- ATAN ROM (Q3.13), index 0..10: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8.
- DONE:
  - out_valid=1 for exactly one cycle; then go to IDLE.
  - z_res holds final z.
- Output stability: index_cor, XM, YM, XR, YR, z_res and out_clamped stay stable from the DONE cycle until the next job's DONE.
  - Internal working registers are separate from the output registers.
  - The downstream chain therefore sees no intermediate values.
- Timing (accept on edge 0):
  - Bits are computed on edges 1..11.
  - out_valid is high in the cycle after edge 11.
  - in_ready returns after edge 12.
  - Throughput: one job per 13 cycles.
- in_valid while in ITER or DONE is ignored; there is no queueing.
- No downstream backpressure: the pipeline never stalls.

Test Plan:
- Reset check: assert reset low mid-sim → all outputs 0 and in_ready=1 immediately, asynchronously (no clock edge needed).
- Zero angle: angle=0, x_in=0x1000, y_in=0 → after 12 cycles, out_valid pulses with index_cor=0x0D1, z_res=0xFFFF (-1), XM=XR=0x1000, YM=YR=0, out_clamped=0.
- Pi/4: angle=6434 → index_cor=0x783, z_res=3, out_clamped=0.
- Clamp: angle=20000 → out_clamped=1 and result identical to angle=12868. Repeat with angle=-20000 → clamped to -12868.
- Busy handling: hold in_valid=1 continuously with changing data → jobs accepted only every 13 cycles. Each out_valid carries the data captured at its own accept edge. Outputs are stable between strobes.
- Abort: drive reset low at iteration 5, then release and submit angle=0 → no stale strobe appears; the new job returns 0x0D1 after exactly 12 cycles.
